intt_scale_ctrl: RTL and testbench

- Sequencer for the final n^-1 scaling of the inverse NTT. Scaling is done as repeated modular halving.
- The block streams a coefficient memory through the shared halve-mod-q unit for SHIFTS passes. Each pass reads a word, halves it mod q, and writes it back in place.
- It sits between the INTT butterfly controller and the coefficient RAM. It drives the halving unit's din/mod inputs and consumes its registered 1-cycle output.

---
 rtl/intt_scale_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_intt_scale_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/intt_scale_ctrl.sv
// ---------------------------------------------------------------------------
// intt_scale_ctrl
//
// Sequences the final n^-1 scaling of the inverse NTT as S passes of
// in-place modular halving over an N-word coefficient RAM. Each pass streams
// every word through an external halve-mod-q unit (1-cycle registered) and
// writes the result back to the address it came from.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           single-cycle request (accepted only in IDLE)
//   mod_sel         1 = q1 16515073, 0 = q2 33292289 (latched at start)
//   shifts          number of halving passes S (latched at start)
//   busy, done      busy in RUN/DRAIN; done is a one-cycle completion pulse
//   rd_en/rd_addr   RAM read port, data returns on rd_data one cycle later
//   div_din/div_mod operand and modulus select to the halving unit
//   div_dout        halving result, one cycle after div_din
//   wr_en/wr_addr/wr_data  RAM write port (write-back of div_dout)
//   cycle_cnt       busy-cycle counter, only with SCALE_PERF_CNT_EN defined
//
// Optional feature macro: SCALE_PERF_CNT_EN
// ---------------------------------------------------------------------------
module intt_scale_ctrl #(
    parameter int N  = 256,
    parameter int AW = 8,
    parameter int DW = 25,
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mod_sel,
    input  logic [SW-1:0] shifts,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic [DW-1:0] div_din,
    output logic          div_mod,
    input  logic [DW-1:0] div_dout,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data
`ifdef SCALE_PERF_CNT_EN
    ,
    output logic [31:0]   cycle_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [SW-1:0] pass_q, pass_d;
    logic [SW-1:0] shifts_q, shifts_d;
    logic          mod_q, mod_d;
    logic          drain_q, drain_d;

    // Read address / enable pipeline: p1 lines up with div_din, p2 with div_dout
    logic          vld_p1_q, vld_p1_d;
    logic          vld_p2_q, vld_p2_d;
    logic [AW-1:0] addr_p1_q, addr_p1_d;
    logic [AW-1:0] addr_p2_q, addr_p2_d;

    logic [SW-1:0] pass_next;

    assign pass_next = pass_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        pass_d   = pass_q;
        shifts_d = shifts_q;
        mod_d    = mod_q;
        drain_d  = drain_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mod_d    = mod_sel;
                    shifts_d = shifts;
                    addr_d   = '0;
                    pass_d   = '0;
                    state_d  = (shifts == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (addr_q == AW'(N - 1)) begin
                    addr_d  = '0;
                    drain_d = 1'b0;
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                // Second drain cycle: the last write of this pass lands now,
                // so the next pass may start reading on the following cycle.
                if (!drain_q) begin
                    drain_d = 1'b1;
                end else begin
                    drain_d = 1'b0;
                    pass_d  = pass_next;
                    state_d = (pass_next == shifts_q) ? DONE : RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rd_en   = (state_q == RUN);
    assign rd_addr = addr_q;
    assign busy    = (state_q == RUN) || (state_q == DRAIN);
    assign done    = (state_q == DONE);
    assign div_din = rd_data;
    assign div_mod = mod_q;

    // Stage p1: RAM data on div_din; stage p2: halved result on div_dout
    always_comb begin
        vld_p1_d  = rd_en;
        addr_p1_d = addr_q;
        vld_p2_d  = vld_p1_q;
        addr_p2_d = addr_p1_q;
    end

    assign wr_en   = vld_p2_q;
    assign wr_addr = addr_p2_q;
    assign wr_data = div_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            pass_q    <= '0;
            shifts_q  <= '0;
            mod_q     <= 1'b0;
            drain_q   <= 1'b0;
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            addr_p1_q <= '0;
            addr_p2_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            pass_q    <= pass_d;
            shifts_q  <= shifts_d;
            mod_q     <= mod_d;
            drain_q   <= drain_d;
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
            addr_p1_q <= addr_p1_d;
            addr_p2_q <= addr_p2_d;
        end
    end

`ifdef SCALE_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        if ((state_q == IDLE) && start) begin
            cycle_cnt_d = '0;
        end else if (busy) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_intt_scale_ctrl.sv
// ---------------------------------------------------------------------------
// tb_intt_scale_ctrl
//
// Bench for intt_scale_ctrl with N=8. Provides a registered-read RAM model and
// a 1-cycle registered halve-mod-q model around the sequencer.
// ---------------------------------------------------------------------------
module tb_intt_scale_ctrl;

    localparam int N  = 8;
    localparam int AW = 3;
    localparam int DW = 25;
    localparam int SW = 4;
    localparam longint Q1 = 16515073;
    localparam longint Q2 = 33292289;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mod_sel;
    logic [SW-1:0] shifts;
    logic          busy, done, rd_en, wr_en, div_mod;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] rd_data, div_din, div_dout, wr_data;
`ifdef SCALE_PERF_CNT_EN
    logic [31:0]   cycle_cnt;
`endif

    always #5 clk = ~clk;

    intt_scale_ctrl #(.N(N), .AW(AW), .DW(DW), .SW(SW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mod_sel  (mod_sel),
        .shifts   (shifts),
        .busy     (busy),
        .done     (done),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .div_din  (div_din),
        .div_mod  (div_mod),
        .div_dout (div_dout),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
`ifdef SCALE_PERF_CNT_EN
        .cycle_cnt(cycle_cnt),
`endif
        .wr_data  (wr_data)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] halve(input logic [DW-1:0] x, input logic m);
        longint q;
        longint t;
        q = m ? Q1 : Q2;
        t = longint'(x);
        if (t % 2 == 1) t = t + q;
        return DW'(t / 2);
    endfunction

    // RAM and halving-unit models
    logic [DW-1:0] mem [N];

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        if (wr_en) mem[wr_addr] <= wr_data;
        div_dout <= halve(div_din, div_mod);
    end

    // Scoreboard: every issued read predicts the write that must follow
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } sb_t;
    sb_t sbq[$];

    logic exp_mod;
    int   busy_cnt, done_cnt, rd_cnt, wr_cnt, gap_cnt;

    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
        end else begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (rd_en) rd_cnt++;
            if (wr_en) wr_cnt++;
            if (busy && !rd_en) gap_cnt++;
            if (busy) check("div_mod", div_mod, exp_mod);
            if (rd_en) sbq.push_back('{a: rd_addr, d: halve(mem[rd_addr], exp_mod)});
            if (wr_en) begin
                if (sbq.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    sb_t e;
                    e = sbq.pop_front();
                    check("wr_addr", wr_addr, e.a);
                    check("wr_data", wr_data, e.d);
                end
            end
        end
    end

    typedef struct {
        logic m;
        int   s;
        int   a0, v0, e0;
        int   a1, v1, e1;
        int   busy;
    } vec_t;
    vec_t vecs[4];

    logic [DW-1:0] ref_mem [N];

    task automatic clear_counts();
        busy_cnt = 0; done_cnt = 0; rd_cnt = 0; wr_cnt = 0; gap_cnt = 0;
    endtask

    task automatic load_mem(input logic m, input int s, input vec_t v);
        longint q;
        q = m ? Q1 : Q2;
        for (int i = 0; i < N; i++) mem[i] = DW'($urandom_range(0, 32'(q - 1)));
        mem[v.a0] = DW'(v.v0);
        mem[v.a1] = DW'(v.v1);
        for (int i = 0; i < N; i++) begin
            ref_mem[i] = mem[i];
            for (int k = 0; k < s; k++) ref_mem[i] = halve(ref_mem[i], m);
        end
    endtask

    task automatic start_pulse(input logic m, input int s);
        @(posedge clk); #1;
        start = 1'b1; mod_sel = m; shifts = SW'(s);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (done_cnt > 0) break;
        end
        check({name, "_done_seen"}, (done_cnt > 0) ? 1 : 0, 1);
        repeat (4) @(negedge clk);
        check({name, "_done_count"}, done_cnt, 1);
    endtask

    task automatic check_mem(input string name, input vec_t v);
        check({name, "_e0"}, mem[v.a0], v.e0);
        check({name, "_e1"}, mem[v.a1], v.e1);
        for (int i = 0; i < N; i++) check({name, "_mem"}, mem[i], ref_mem[i]);
        check({name, "_sb_empty"}, sbq.size(), 0);
    endtask

    initial begin
        vecs[0] = '{m: 1'b1, s: 1, a0: 0, v0: 3, e0: 8257538, a1: 1, v1: 4, e1: 2,        busy: 10};
        vecs[1] = '{m: 1'b1, s: 2, a0: 2, v0: 4, e0: 1,       a1: 3, v1: 1, e1: 12386305, busy: 20};
        vecs[2] = '{m: 1'b0, s: 3, a0: 5, v0: 1, e0: 29130753, a1: 4, v1: 8, e1: 1,       busy: 30};
        vecs[3] = '{m: 1'b1, s: 0, a0: 0, v0: 5, e0: 5,       a1: 1, v1: 7, e1: 7,        busy: 0};

        rst = 1'b1; start = 1'b0; mod_sel = 1'b0; shifts = '0; exp_mod = 1'b0;
        rd_data = '0; div_dout = '0;
        clear_counts();
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_div_mod", div_mod, 0);
        #1 rst = 1'b0;

        // Table-driven operations
        for (int t = 0; t < 4; t++) begin
            load_mem(vecs[t].m, vecs[t].s, vecs[t]);
            exp_mod = vecs[t].m;
            clear_counts();
            start_pulse(vecs[t].m, vecs[t].s);
            if (vecs[t].s == 0) begin
                @(negedge clk);
                check("s0_done_next", done, 1);
            end
            wait_done($sformatf("vec%0d", t));
            check($sformatf("vec%0d_busy_cycles", t), busy_cnt, vecs[t].busy);
            check($sformatf("vec%0d_rd_gap", t), gap_cnt, 2 * vecs[t].s);
            check($sformatf("vec%0d_rd_cnt", t), rd_cnt, N * vecs[t].s);
            check($sformatf("vec%0d_wr_cnt", t), wr_cnt, N * vecs[t].s);
`ifdef SCALE_PERF_CNT_EN
            check($sformatf("vec%0d_cycle_cnt", t), cycle_cnt, vecs[t].busy);
`endif
            check_mem($sformatf("vec%0d", t), vecs[t]);
        end

        // Second start mid-RUN with different settings must be ignored
        load_mem(1'b1, 1, vecs[0]);
        exp_mod = 1'b1;
        clear_counts();
        start_pulse(1'b1, 1);
        repeat (2) @(posedge clk);
        #1 start = 1'b1; mod_sel = 1'b0; shifts = SW'(3);
        @(posedge clk); #1 start = 1'b0;
        wait_done("restart");
        check("restart_busy_cycles", busy_cnt, N + 2);
        check_mem("restart", vecs[0]);

        // Reset during pass 2 of an S=3 operation
        load_mem(1'b1, 3, vecs[1]);
        exp_mod = 1'b1;
        clear_counts();
        start_pulse(1'b1, 3);
        repeat (N + 5) @(negedge clk);
        check("abort_busy_before", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_rd_en", rd_en, 0);
        check("abort_wr_en", wr_en, 0);
        check("abort_rd_addr", rd_addr, 0);
        check("abort_wr_addr", wr_addr, 0);
        check("abort_div_mod", div_mod, 0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_no_done", done_cnt, 0);
        check("abort_idle", busy, 0);

        // Fresh S=1 operation after the abort completes normally
        load_mem(1'b1, 1, vecs[0]);
        exp_mod = 1'b1;
        clear_counts();
        start_pulse(1'b1, 1);
        wait_done("post_abort");
        check("post_abort_busy_cycles", busy_cnt, N + 2);
        check_mem("post_abort", vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
